// File: rtl/hwpe_stream_package.sv
// Shared types and constants for the HWPE stream/TCDM blocks.
// Holds the reader FSM state encoding and the fixed TCDM word format.
package hwpe_stream_package;

    localparam int unsigned TCDM_DATA_WIDTH = 32;
    localparam logic [3:0]  TCDM_BE_ALL     = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } reader_state_e;

endpackage

// File: rtl/hwpe_stream_interfaces.sv
// TCDM memory port and valid/ready word stream used by the HWPE blocks.
// Direction is given by the modports: master/slave for TCDM, source/sink for streams.
interface hwpe_stream_intf_tcdm;
    logic        req;
    logic        gnt;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] r_data;
    logic        r_valid;

    modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
    modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport source (output valid, data, strb, input ready);
    modport sink   (input valid, data, strb, output ready);
endinterface

// File: rtl/hwpe_stream_fifo.sv
// Circular response buffer between a stream sink and a stream source.
// A full FIFO still accepts a push in the same cycle as a pop.
module hwpe_stream_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    hwpe_stream_intf_stream.sink          push_i,
    hwpe_stream_intf_stream.source        pop_o,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  full, empty, do_push, do_pop;

    assign full    = (occ_q == OCC_W'(FIFO_DEPTH));
    assign empty   = (occ_q == '0);
    assign do_pop  = pop_o.valid && pop_o.ready;
    assign do_push = push_i.valid && push_i.ready;

    assign push_i.ready = !full || pop_o.ready;
    assign pop_o.valid  = !empty;
    assign pop_o.data   = mem_q[rd_ptr_q];
    assign pop_o.strb   = '1;
    assign occupancy_o  = occ_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_i.data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Upstream credit accounting must make a refused push impossible.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push_i.valid && !push_i.ready));
            assert (!push_i.valid || (&push_i.strb));
        end
    end

endmodule

// File: rtl/hwpe_stream_tcdm_reader.sv
// Strided TCDM reader: issues word reads base + n*stride and streams the responses out.
// Requests are credit-limited so responses in flight never exceed the buffer depth.
module hwpe_stream_tcdm_reader
    import hwpe_stream_package::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [31:0]           base_addr_i,
    input  logic [31:0]           stride_i,
    input  logic [CNT_WIDTH-1:0]  word_count_i,
    output logic                  busy_o,
    output logic                  done_o,
    hwpe_stream_intf_tcdm.master  tcdm,
    hwpe_stream_intf_stream.source stream
);

    localparam int unsigned SUM_W = $clog2(FIFO_DEPTH) + 1;

    reader_state_e         state_q, state_d;
    logic [CNT_WIDTH-1:0]  issued_q, issued_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [CNT_WIDTH-1:0]  outstanding_q, outstanding_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           stride_q, stride_d;
    logic                  done_zero_q, done_zero_d;

    logic [SUM_W-1:0]      occupancy;
    logic [SUM_W-1:0]      credit_sum;
    logic                  tcdm_req, grant, accept, drain_done;

    hwpe_stream_intf_stream #(.DATA_WIDTH(TCDM_DATA_WIDTH)) push_if ();

    assign credit_sum = SUM_W'(outstanding_q) + occupancy;
    assign tcdm_req   = (state_q == REQ) && (issued_q < count_q)
                        && (credit_sum < SUM_W'(FIFO_DEPTH));
    assign grant      = tcdm_req && tcdm.gnt;
    // Responses that arrive while idle belong to an aborted transfer and are dropped.
    assign accept     = tcdm.r_valid && (state_q != IDLE);

    assign tcdm.req  = tcdm_req;
    assign tcdm.add  = addr_q;
    assign tcdm.wen  = 1'b1;
    assign tcdm.be   = TCDM_BE_ALL;
    assign tcdm.data = '0;

    assign push_if.valid = accept;
    assign push_if.data  = tcdm.r_data;
    assign push_if.strb  = TCDM_BE_ALL;

    assign busy_o = (state_q != IDLE);
    assign done_o = done_zero_q || drain_done;

    always_comb begin
        state_d       = state_q;
        issued_d      = issued_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        addr_d        = addr_q;
        stride_d      = stride_q;
        done_zero_d   = 1'b0;
        drain_done    = 1'b0;

        if (grant) begin
            issued_d = issued_q + CNT_WIDTH'(1);
            addr_d   = addr_q + stride_q;
        end
        case ({grant, accept})
            2'b10:   outstanding_d = outstanding_q + CNT_WIDTH'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_WIDTH'(1);
            default: outstanding_d = outstanding_q;
        endcase

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (word_count_i != '0) begin
                        addr_d        = base_addr_i;
                        stride_d      = stride_i;
                        count_d       = word_count_i;
                        issued_d      = '0;
                        outstanding_d = '0;
                        state_d       = REQ;
                    end else begin
                        done_zero_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (issued_d == count_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((outstanding_q == '0) && (occupancy == '0)) begin
                    drain_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            issued_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            addr_q        <= '0;
            stride_q      <= '0;
            done_zero_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            issued_q      <= issued_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            addr_q        <= addr_d;
            stride_q      <= stride_d;
            done_zero_q   <= done_zero_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (outstanding_q <= CNT_WIDTH'(FIFO_DEPTH));
        end
    end

    hwpe_stream_fifo #(
        .DATA_WIDTH (TCDM_DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) i_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push_if),
        .pop_o       (stream),
        .occupancy_o (occupancy)
    );

endmodule

// File: tb/tb_hwpe_stream_tcdm_reader.sv
// Directed bench for hwpe_stream_tcdm_reader with a reactive TCDM responder.
// Memory contents are a fixed function of the address so stream data is predictable.
module tb_hwpe_stream_tcdm_reader;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned CNT_WIDTH  = 16;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 start_i;
    logic [31:0]          base_addr_i;
    logic [31:0]          stride_i;
    logic [CNT_WIDTH-1:0] word_count_i;
    logic                 busy_o;
    logic                 done_o;

    hwpe_stream_intf_tcdm                      tcdm_if ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) stream_if ();

    hwpe_stream_tcdm_reader #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .stride_i     (stride_i),
        .word_count_i (word_count_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .tcdm         (tcdm_if),
        .stream       (stream_if)
    );

    always #5 clk_i = ~clk_i;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          gnt_mode     = 1;
    logic        gnt_drv      = 1'b0;
    logic        ready_drv    = 1'b1;
    logic        hs_pend      = 1'b0;
    logic [31:0] addr_pend    = '0;
    logic        slv_rvalid   = 1'b0;
    logic [31:0] slv_rdata    = '0;
    logic        man_rvalid   = 1'b0;
    logic [31:0] man_rdata    = '0;
    logic        stall_prev   = 1'b0;
    logic [31:0] stall_addr   = '0;
    logic        hold_prev    = 1'b0;
    logic [31:0] hold_data    = '0;
    int          done_cnt     = 0;
    logic [31:0] addr_log [$];
    logic [31:0] rx_log   [$];

    assign tcdm_if.gnt     = gnt_drv;
    assign tcdm_if.r_valid = slv_rvalid | man_rvalid;
    assign tcdm_if.r_data  = man_rvalid ? man_rdata : slv_rdata;
    assign stream_if.ready = ready_drv;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3C3_5A5A;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] base, input logic [31:0] stride,
                                 input logic [CNT_WIDTH-1:0] cnt);
        @(posedge clk_i); #1;
        addr_log.delete();
        rx_log.delete();
        done_cnt     = 0;
        base_addr_i  = base;
        stride_i     = stride;
        word_count_i = cnt;
        start_i      = 1'b1;
        @(posedge clk_i); #1;
        start_i      = 1'b0;
    endtask

    task automatic waitIdle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (!busy_o && done_cnt > 0) break;
        end
        @(negedge clk_i);
        checkOutput({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        checkOutput({tag, "_busy_after"}, {31'b0, busy_o}, 32'd0);
    endtask

    task automatic checkTransfer(input string tag, input logic [31:0] base,
                                 input logic [31:0] stride, input int n);
        logic [31:0] exp_addr;
        logic [31:0] got;
        checkOutput({tag, "_grants"}, 32'(addr_log.size()), 32'(n));
        checkOutput({tag, "_words"}, 32'(rx_log.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            exp_addr = base + stride * 32'(i);
            got = (i < addr_log.size()) ? addr_log[i] : 32'hxxxx_xxxx;
            checkOutput($sformatf("%s_addr%0d", tag, i), got, exp_addr);
            got = (i < rx_log.size()) ? rx_log[i] : 32'hxxxx_xxxx;
            checkOutput($sformatf("%s_data%0d", tag, i), got, mem_data(exp_addr));
        end
    endtask

    // Monitor: handshakes observed at the falling edge complete on the next rising edge.
    always @(negedge clk_i) begin
        hs_pend   = tcdm_if.req && tcdm_if.gnt;
        addr_pend = tcdm_if.add;
        if (hs_pend) begin
            addr_log.push_back(tcdm_if.add);
            checkOutput("req_wen", {31'b0, tcdm_if.wen}, 32'd1);
            checkOutput("req_be", {28'b0, tcdm_if.be}, 32'h0000_000F);
        end
        if (stream_if.valid && ready_drv) rx_log.push_back(stream_if.data);
        if (done_o) done_cnt++;
        if (!rst_i && stall_prev) begin
            checkOutput("req_hold", {31'b0, tcdm_if.req}, 32'd1);
            checkOutput("add_hold", tcdm_if.add, stall_addr);
        end
        if (!rst_i && hold_prev) begin
            checkOutput("valid_hold", {31'b0, stream_if.valid}, 32'd1);
            checkOutput("data_hold", stream_if.data, hold_data);
        end
        stall_prev = !rst_i && tcdm_if.req && !tcdm_if.gnt;
        stall_addr = tcdm_if.add;
        hold_prev  = !rst_i && stream_if.valid && !ready_drv;
        hold_data  = stream_if.data;
    end

    // Responder: one-cycle read latency, grant policy selected by gnt_mode.
    always @(posedge clk_i) begin
        #1;
        slv_rvalid = hs_pend;
        slv_rdata  = mem_data(addr_pend);
        gnt_drv    = (gnt_mode == 2) ? 1'($urandom_range(0, 1)) : (gnt_mode == 1);
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_i        = 1'b1;
        start_i      = 1'b0;
        base_addr_i  = '0;
        stride_i     = '0;
        word_count_i = '0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;

        @(negedge clk_i);
        checkOutput("rst_busy", {31'b0, busy_o}, 32'd0);
        checkOutput("rst_done", {31'b0, done_o}, 32'd0);
        checkOutput("rst_req", {31'b0, tcdm_if.req}, 32'd0);
        checkOutput("rst_valid", {31'b0, stream_if.valid}, 32'd0);
        checkOutput("rst_strb", {28'b0, stream_if.strb}, 32'h0000_000F);

        // Scenario 1: back-to-back grants, always-ready sink.
        gnt_mode  = 1;
        ready_drv = 1'b1;
        applyStimulus(32'h0000_1000, 32'd4, 16'd8);
        checkOutput("s1_busy", {31'b0, busy_o}, 32'd1);
        waitIdle("s1", 100);
        checkTransfer("s1", 32'h0000_1000, 32'd4, 8);
        checkOutput("s1_last_addr", (addr_log.size() > 7) ? addr_log[7] : 32'hDEAD_BEEF,
                    32'h0000_101C);

        // Scenario 2: sink stalled, credits cap the number of grants at the buffer depth.
        ready_drv = 1'b0;
        applyStimulus(32'h0000_3000, 32'd4, 16'd6);
        repeat (18) @(negedge clk_i);
        checkOutput("s2_grants_capped", 32'(addr_log.size()), 32'(FIFO_DEPTH));
        checkOutput("s2_req_low", {31'b0, tcdm_if.req}, 32'd0);
        checkOutput("s2_valid", {31'b0, stream_if.valid}, 32'd1);
        checkOutput("s2_head", stream_if.data, mem_data(32'h0000_3000));
        checkOutput("s2_busy", {31'b0, busy_o}, 32'd1);
        @(posedge clk_i); #1 ready_drv = 1'b1;
        waitIdle("s2", 100);
        checkTransfer("s2", 32'h0000_3000, 32'd4, 6);

        // Scenario 3: random grant stalls with a non-unit stride.
        gnt_mode = 2;
        applyStimulus(32'h0000_2000, 32'd8, 16'd8);
        waitIdle("s3", 300);
        checkTransfer("s3", 32'h0000_2000, 32'd8, 8);
        gnt_mode = 1;

        // Scenario 4: address wraps past the top of the 32-bit space.
        applyStimulus(32'hFFFF_FFF8, 32'd4, 16'd4);
        waitIdle("s4", 100);
        checkTransfer("s4", 32'hFFFF_FFF8, 32'd4, 4);
        checkOutput("s4_wrap_addr2", (addr_log.size() > 2) ? addr_log[2] : 32'hDEAD_BEEF,
                    32'h0000_0000);

        // Scenario 5: zero-length transfer completes immediately.
        applyStimulus(32'h0000_6000, 32'd4, 16'd0);
        @(negedge clk_i);
        checkOutput("s5_done_next", {31'b0, done_o}, 32'd1);
        checkOutput("s5_busy", {31'b0, busy_o}, 32'd0);
        repeat (5) @(negedge clk_i);
        checkOutput("s5_no_req", 32'(addr_log.size()), 32'd0);
        checkOutput("s5_valid", {31'b0, stream_if.valid}, 32'd0);
        checkOutput("s5_done_pulses", 32'(done_cnt), 32'd1);

        // Scenario 6: reset mid-transfer, then stale responses, then a fresh transfer.
        applyStimulus(32'h0000_4000, 32'd4, 16'd8);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (addr_log.size() >= 3) break;
        end
        checkOutput("s6_pre_grants", {31'b0, addr_log.size() >= 3}, 32'd1);
        @(posedge clk_i); #1 rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("s6_busy_rst", {31'b0, busy_o}, 32'd0);
        checkOutput("s6_valid_rst", {31'b0, stream_if.valid}, 32'd0);
        @(posedge clk_i); #1;
        man_rdata  = 32'hDEAD_BEEF;
        man_rvalid = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 man_rvalid = 1'b0;
        @(negedge clk_i);
        checkOutput("s6_late_valid", {31'b0, stream_if.valid}, 32'd0);
        checkOutput("s6_late_busy", {31'b0, busy_o}, 32'd0);
        checkOutput("s6_late_req", {31'b0, tcdm_if.req}, 32'd0);
        applyStimulus(32'h0000_5000, 32'h0000_0010, 16'd2);
        waitIdle("s6", 100);
        checkTransfer("s6", 32'h0000_5000, 32'h0000_0010, 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
